lcd_image_overlay: RTL
======================

Name: lcd_image_overlay

Overview:
- Downstream consumer of the 480x272 LCD timing generator.
- Takes the generator's hs/vs/de and active x/y, and places a fixed-size 8-bit grayscale fingerprint image, read from an external synchronous image RAM, at a programmable window position.
- Draws a 1-pixel border around the window and fills everything else with a background colour.
- Drives RGB565 plus the matching, delayed sync signals to the LCD pins, with frame-level handshakes to the image producer.

Parameters:
IMG_W, 192, image width in pixels
IMG_H, 192, image height in lines
IMG_X0, 144, first active column of image window
IMG_Y0, 40, first active line of image window
ADDR_W, 16, image RAM address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)
VS_POL, 1'b0, active level of in_vs
BG_COLOR, 16'h0000, RGB565 background
BORDER_COLOR, 16'hFFFF, RGB565 border

Ports:
clk  in  1  pixel clock (9 MHz)
rst_n  in  1  asynchronous active-low reset
in_hs  in  1  horizontal sync from timing generator
in_vs  in  1  vertical sync from timing generator
in_de  in  1  video active from timing generator
in_x  in  10  active column, valid while in_de=1
in_y  in  10  active line, valid while in_de=1
img_frame_rdy  in  1  producer has a complete image in RAM
img_rd_en  out  1  image RAM read strobe
img_addr  out  ADDR_W  image RAM read address
img_rdata  in  8  grayscale data, valid exactly 1 cycle after img_rd_en/img_addr
frame_done  out  1  1-cycle pulse: last image pixel fetched this frame
showing  out  1  current frame displays the image
lcd_hs  out  1  in_hs delayed 3 cycles
lcd_vs  out  1  in_vs delayed 3 cycles
lcd_de  out  1  in_de delayed 3 cycles
lcd_rgb  out  16  RGB565 pixel aligned with lcd_de

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - All outputs are 0. img_addr=0. Delay line is cleared. State is IDLE.
- Frame start: a registered edge detect of in_vs going into the VS_POL level.
  - At frame start, img_addr is cleared to 0.
  - IDLE -> SHOW if img_frame_rdy=1; otherwise the state stays or returns to IDLE.
  - SHOW -> IDLE at the next frame start if img_frame_rdy=0.
  - State changes only at frame start. img_frame_rdy changes mid-frame are ignored.
  - showing equals (state==SHOW).
- Pixel classification, stage 0, combinational from in_de/in_x/in_y:
  - WIN: IMG_X0 <= x < IMG_X0+IMG_W and IMG_Y0 <= y < IMG_Y0+IMG_H.
  - BORDER: x or y on the ring one pixel outside WIN, inside the active area.
  - BG: all other pixels.
  - Pixels with de=0 output 0.
- Fetch, stage 1, registered:
  - img_rd_en=1 iff WIN and de and SHOW.
  - img_addr holds the current counter value.
  - The counter increments after each issued read.
  - No multiplier is used; the address follows raster order, so after the window's last column on line n the next read is (n+1-IMG_Y0)*IMG_W.
- Stage 2: img_rdata is valid. The class bits are carried alongside it.
- Stage 3, registered output:
  - WIN&SHOW: lcd_rgb = {g[7:3], g[7:2], g[7:3]}.
  - WIN&IDLE: BG_COLOR.
  - BORDER: BORDER_COLOR.
  - BG: BG_COLOR.
  - de=0: 16'h0000.
- Latency: fixed 3 cycles from in_* to lcd_*. hs, vs and de go through the same 3-stage delay line.
- frame_done:
  - Pulses for 1 cycle, coincident with the img_rd_en cycle whose img_addr = IMG_W*IMG_H-1.
  - Only fires in SHOW, at most once per frame.
- Counter wrap: the counter never exceeds IMG_W*IMG_H-1 within a frame. If extra WIN pixels occur (malformed timing), the address saturates and reads stop.
- Reset mid-frame:
  - Outputs drop to 0 asynchronously.
  - After release, the state is IDLE, so the remaining lines show background/border only.
  - The image is shown from the first full frame start with img_frame_rdy=1.

Decomposition:
- Shared package lcd_pkg:
  - rgb565 typedef.
  - Colour constants (black, white).
  - gray_to_rgb565 function.
  - State enum {IDLE, SHOW}.
  - Pixel-class enum {PX_NONE, PX_BG, PX_BORDER, PX_WIN}.
- One sub-module: lcd_sig_delay, a parameterised width/depth shift register with asynchronous active-low clear. It is instantiated for {hs, vs, de, class}.

Test Plan:
1. rst_n=0 for 5 cycles mid-line -> lcd_rgb=0, lcd_de=0, img_rd_en=0, frame_done=0, showing=0 throughout.
2. Full frame with img_frame_rdy=0 -> no img_rd_en; lcd_rgb=16'hFFFF at (143,39) and (336,232); 16'h0000 at (144,40) and (0,0); lcd_de rises exactly 3 clocks after in_de.
3. img_frame_rdy=1 before frame start, RAM model returns data=addr[7:0]:
   - (144,40) reads addr 0 -> rgb 16'h0000.
   - (145,40) reads addr 1.
   - (144,41) reads addr 192.
   - addr 0xFF -> rgb 16'hFFFF.
   - frame_done pulses once with img_addr=36863.
4. img_frame_rdy drops at line 100 -> current frame completes in SHOW with frame_done; next frame showing=0, no reads.
5. rst_n pulsed low at line 100 during SHOW -> outputs 0 immediately; rest of frame is IDLE; next frame with rdy=1 starts at addr 0.
6. Sync alignment -> lcd_hs/lcd_vs equal in_hs/in_vs delayed exactly 3 cycles over two consecutive full frames.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, colours and helpers for the LCD image overlay
package lcd_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RGB_BLACK = 16'h0000;
  localparam rgb565_t RGB_WHITE = 16'hFFFF;

  // Visible area of the 480x272 panel driven by the upstream timing generator.
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;

  typedef enum logic {IDLE, SHOW} state_e;

  typedef enum logic [1:0] {PX_NONE, PX_BG, PX_BORDER, PX_WIN} px_class_e;

  function automatic rgb565_t gray_to_rgb565(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

// File: rtl/lcd_sig_delay.sv
// rtl/lcd_sig_delay.sv - fixed-depth shift register with asynchronous clear
module lcd_sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/lcd_image_overlay.sv
// rtl/lcd_image_overlay.sv - places a RAM-backed grayscale image in a bordered window
// on the LCD raster and drives RGB565 with syncs delayed to match.
module lcd_image_overlay
  import lcd_pkg::*;
#(
  parameter int      IMG_W        = 192,
  parameter int      IMG_H        = 192,
  parameter int      IMG_X0       = 144,
  parameter int      IMG_Y0       = 40,
  parameter int      ADDR_W       = 16,
  parameter logic    VS_POL       = 1'b0,
  parameter rgb565_t BG_COLOR     = RGB_BLACK,
  parameter rgb565_t BORDER_COLOR = RGB_WHITE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  input  logic              img_frame_rdy,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic              frame_done,
  output logic              showing,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [15:0]       lcd_rgb
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  int        x_i, y_i;
  logic      in_win_x, in_win_y, in_ring_x, in_ring_y;
  px_class_e cls0;
  logic      rd0;
  logic      frame_start;

  state_e            state_q, state_d;
  logic              vs_prev_q, vs_prev_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] img_addr_q, img_addr_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              frame_done_q, frame_done_d;
  rgb565_t           rgb_q, rgb_d;

  logic [2:0] cls_rd2;
  px_class_e  cls2;
  logic       rd2;

  always_comb begin
    x_i = {22'd0, in_x};
    y_i = {22'd0, in_y};
    in_win_x  = (x_i >= IMG_X0) && (x_i < IMG_X0 + IMG_W);
    in_win_y  = (y_i >= IMG_Y0) && (y_i < IMG_Y0 + IMG_H);
    in_ring_x = (x_i >= IMG_X0 - 1) && (x_i <= IMG_X0 + IMG_W) && (x_i < H_ACTIVE);
    in_ring_y = (y_i >= IMG_Y0 - 1) && (y_i <= IMG_Y0 + IMG_H) && (y_i < V_ACTIVE);
    cls0 = PX_NONE;
    if (in_de) begin
      if (in_win_x && in_win_y) begin
        cls0 = PX_WIN;
      end else if (in_ring_x && in_ring_y) begin
        cls0 = PX_BORDER;
      end else begin
        cls0 = PX_BG;
      end
    end
  end

  assign frame_start = (in_vs == VS_POL) && (vs_prev_q != VS_POL);

  // Raster-order counter replaces (y-Y0)*W+(x-X0); done_q stops reads once the
  // last address went out, so malformed timing cannot run past the image.
  always_comb begin
    vs_prev_d    = in_vs;
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    img_addr_d   = img_addr_q;
    rd0          = (cls0 == PX_WIN) && (state_q == SHOW) && !done_q;
    rd_en_d      = rd0;
    frame_done_d = rd0 && (cnt_q == LAST_ADDR);
    if (frame_start) begin
      state_d    = img_frame_rdy ? SHOW : IDLE;
      cnt_d      = '0;
      done_d     = 1'b0;
      img_addr_d = '0;
    end else if (rd0) begin
      img_addr_d = cnt_q;
      if (cnt_q == LAST_ADDR) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  lcd_sig_delay #(.WIDTH(3), .DEPTH(3)) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_hs, in_vs, in_de}),
    .dout ({lcd_hs, lcd_vs, lcd_de})
  );

  lcd_sig_delay #(.WIDTH(3), .DEPTH(2)) u_class_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({cls0, rd0}),
    .dout (cls_rd2)
  );

  assign cls2 = px_class_e'(cls_rd2[2:1]);
  assign rd2  = cls_rd2[0];

  always_comb begin
    rgb_d = RGB_BLACK;
    case (cls2)
      PX_WIN:    rgb_d = rd2 ? gray_to_rgb565(img_rdata) : BG_COLOR;
      PX_BORDER: rgb_d = BORDER_COLOR;
      PX_BG:     rgb_d = BG_COLOR;
      default:   rgb_d = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_prev_q    <= VS_POL;
      cnt_q        <= '0;
      img_addr_q   <= '0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      rgb_q        <= RGB_BLACK;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_prev_d;
      cnt_q        <= cnt_d;
      img_addr_q   <= img_addr_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
      rgb_q        <= rgb_d;
    end
  end

  assign img_rd_en  = rd_en_q;
  assign img_addr   = img_addr_q;
  assign frame_done = frame_done_q;
  assign showing    = (state_q == SHOW);
  assign lcd_rgb    = rgb_q;

endmodule
